// File: rtl/pwm_demodulator.sv
// pwm_demodulator: measures the high time of each period on an asynchronous
// PWM line in quanta of TickDiv clocks. It publishes one DataBits-wide sample
// per complete period, with a one-cycle SampleValid strobe. A silence timeout
// reports a line stuck low or stuck high and raises Lost.
//
// Optional build macro: PWM_DEMOD_DEGLITCH_EN
//   When defined, a deglitch filter follows the synchroniser. The filtered
//   line follows the synchronised line only after it has held a new level for
//   4 consecutive clocks. This adds 3 clocks of edge latency.
//
// Output handshake: SampleValid is a single-cycle strobe with no ready or
// backpressure. Sample is valid in the strobe cycle and holds until the next
// strobe. A consumer must capture it in the strobe cycle if it needs the
// event.
module pwm_demodulator #(
  parameter int DataBits       = 8,
  parameter int TickDiv        = 8,
  parameter int SyncStages     = 2,
  parameter int TimeoutPeriods = 4
) (
  input  logic                ClkOsc,
  input  logic                Rst,
  input  logic                In_Pwm,
  output logic [DataBits-1:0] Sample,
  output logic                SampleValid,
  output logic                Lost,
  output logic [1:0]          DbgState
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_e;

  localparam int PreW        = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int SilLimitInt = TimeoutPeriods * (2 ** DataBits);
  localparam int SilW        = $clog2(SilLimitInt) + 1;
`ifdef PWM_DEMOD_DEGLITCH_EN
  localparam int DgExtra     = 3;
`else
  localparam int DgExtra     = 0;
`endif
  // Clocks after reset before the edge detector sees a settled line. Masking
  // edges during this window stops the zeroed synchroniser refilling to a
  // high pin from looking like a real rising edge.
  localparam int FillLen     = SyncStages + 1 + DgExtra;
  localparam int FillW       = $clog2(FillLen + 1);

  localparam logic [PreW-1:0]     PreMax   = PreW'(TickDiv - 1);
  localparam logic [SilW-1:0]     SilLimit = SilW'(SilLimitInt);
  localparam logic [SilW-1:0]     SilLast  = SilW'(SilLimitInt - 1);
  localparam logic [DataBits-1:0] HighMax  = '1;
  localparam logic [FillW-1:0]    FillDone = FillW'(FillLen);

  logic [SyncStages-1:0] r_sync;
  logic                  r_line_d;
  logic [FillW-1:0]      r_fill;
  logic [PreW-1:0]       r_pre;
  logic [SilW-1:0]       r_sil;
  logic                  r_armed;
  state_e                r_state;
  logic [DataBits-1:0]   r_high;
  logic [DataBits-1:0]   r_pend;
  logic [DataBits-1:0]   r_sample;
  logic                  r_valid;
  logic                  r_lost;

  logic                  w_sync;
  logic                  w_line;
  logic                  w_filled;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_edge;
  logic                  w_tick;
  logic                  w_timeout;
  logic [DataBits-1:0]   w_high_inc;
  state_e                w_state_nxt;
  logic [DataBits-1:0]   w_high_nxt;
  logic [DataBits-1:0]   w_pend_nxt;
  logic [DataBits-1:0]   w_sample_nxt;
  logic                  w_valid_nxt;
  logic                  w_lost_nxt;

  // Input synchroniser: shift the asynchronous pin through SyncStages flops.
  always_ff @(posedge ClkOsc) begin
    if (!Rst) r_sync <= '0;
    else      r_sync <= {r_sync[SyncStages-2:0], In_Pwm};
  end

  assign w_sync = r_sync[SyncStages-1];

`ifdef PWM_DEMOD_DEGLITCH_EN
  logic       r_filt;
  logic [1:0] r_dg_cnt;
  logic       w_dg_diff;
  logic       w_dg_take;

  assign w_dg_diff = (w_sync != r_filt);
  assign w_dg_take = w_dg_diff && (r_dg_cnt == 2'd3);
  // On the 4th differing clock the new level is passed straight through.
  // This keeps the added latency at 3 clocks.
  assign w_line    = w_dg_take ? w_sync : r_filt;

  // Deglitch: count consecutive clocks the synchronised line differs from the filtered level.
  always_ff @(posedge ClkOsc) begin
    if (!Rst) begin
      r_filt   <= 1'b0;
      r_dg_cnt <= 2'd0;
    end else if (w_dg_take) begin
      r_filt   <= w_sync;
      r_dg_cnt <= 2'd0;
    end else if (w_dg_diff) begin
      r_dg_cnt <= r_dg_cnt + 2'd1;
    end else begin
      r_dg_cnt <= 2'd0;
    end
  end
`else
  assign w_line = w_sync;
`endif

  // Edge detector delay flop plus the post-reset settling counter.
  always_ff @(posedge ClkOsc) begin
    if (!Rst) begin
      r_line_d <= 1'b0;
      r_fill   <= '0;
    end else begin
      r_line_d <= w_line;
      if (r_fill != FillDone) r_fill <= r_fill + 1'b1;
    end
  end

  assign w_filled  = (r_fill == FillDone);
  assign w_rise    = w_filled &  w_line & ~r_line_d;
  assign w_fall    = w_filled & ~w_line &  r_line_d;
  assign w_edge    = w_rise | w_fall;
  assign w_tick    = (r_pre == PreMax) && !w_rise;
  assign w_timeout = r_armed && w_tick && !w_edge && (r_sil == SilLast);

  // Prescaler, silence counter and timeout arming.
  always_ff @(posedge ClkOsc) begin
    if (!Rst) begin
      r_pre   <= '0;
      r_sil   <= '0;
      r_armed <= 1'b1;
    end else begin
      if (w_rise || (r_pre == PreMax)) r_pre <= '0;
      else                             r_pre <= r_pre + 1'b1;
      if (w_edge)                              r_sil <= '0;
      else if (w_tick && (r_sil != SilLimit))  r_sil <= r_sil + 1'b1;
      if (w_edge)         r_armed <= 1'b1;
      else if (w_timeout) r_armed <= 1'b0;
    end
  end

  assign w_high_inc = (w_tick && (r_high != HighMax)) ? r_high + 1'b1 : r_high;

  // FSM next state and datapath updates. A timeout overrides the normal
  // state flow; by construction it never coincides with an edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_high_nxt   = r_high;
    w_pend_nxt   = r_pend;
    w_sample_nxt = r_sample;
    w_valid_nxt  = 1'b0;
    w_lost_nxt   = r_lost;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nxt = S_HIGH;
          w_high_nxt  = '0;
        end
      end
      S_HIGH: begin
        w_high_nxt = w_high_inc;
        if (w_fall) begin
          w_pend_nxt  = w_high_inc;
          w_state_nxt = S_LOW;
        end
      end
      S_LOW: begin
        if (w_rise) begin
          w_sample_nxt = r_pend;
          w_valid_nxt  = 1'b1;
          w_lost_nxt   = 1'b0;
          w_high_nxt   = '0;
          w_state_nxt  = S_HIGH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) begin
      w_sample_nxt = w_line ? HighMax : '0;
      w_valid_nxt  = 1'b1;
      w_lost_nxt   = 1'b1;
      w_state_nxt  = S_IDLE;
    end
  end

  // FSM state and output registers.
  always_ff @(posedge ClkOsc) begin
    if (!Rst) begin
      r_state  <= S_IDLE;
      r_high   <= '0;
      r_pend   <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_lost   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_high   <= w_high_nxt;
      r_pend   <= w_pend_nxt;
      r_sample <= w_sample_nxt;
      r_valid  <= w_valid_nxt;
      r_lost   <= w_lost_nxt;
    end
  end

  assign Sample      = r_sample;
  assign SampleValid = r_valid;
  assign Lost        = r_lost;
  assign DbgState    = r_state;

endmodule

// File: tb/tb_pwm_demodulator.sv
// Testbench for pwm_demodulator with default parameters: DataBits=8,
// TickDiv=8 and a nominal period of 2048 clocks. A negedge monitor pops
// expected {Lost, Sample} pairs from a queue on every SampleValid strobe.
module tb_pwm_demodulator;

  localparam int DW = 8;

  logic          ClkOsc = 1'b0;
  logic          Rst    = 1'b0;
  logic          In_Pwm = 1'b0;
  logic [DW-1:0] Sample;
  logic          SampleValid;
  logic          Lost;
  logic [1:0]    DbgState;

  logic [DW:0]   exp_q[$];
  int            n_vec = 0;
  int            n_miss = 0;
  logic          prev_valid = 1'b0;

  typedef struct {
    int high;
    int period;
    int exp;
  } vec_t;

  vec_t vecs[6];

  // Clock and DUT.
  always #5 ClkOsc = ~ClkOsc;

  pwm_demodulator #(
    .DataBits(8), .TickDiv(8), .SyncStages(2), .TimeoutPeriods(4)
  ) dut (
    .ClkOsc(ClkOsc), .Rst(Rst), .In_Pwm(In_Pwm),
    .Sample(Sample), .SampleValid(SampleValid), .Lost(Lost),
    .DbgState(DbgState)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected entry.
  always @(negedge ClkOsc) begin
    if (SampleValid) begin
      check("valid_gap", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_valid: got strobe with sample %0d lost %0b, expected none",
                 Sample, Lost);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        check("sample", 32'(Sample), 32'(e[DW-1:0]));
        check("lost", {31'd0, Lost}, {31'd0, e[DW]});
      end
    end
    prev_valid = SampleValid;
  end

  // Driver tasks: inputs change on the falling edge.
  task automatic hold(input logic v, input int n);
    In_Pwm = v;
    repeat (n) @(negedge ClkOsc);
  endtask

  task automatic period(input int h, input int l);
    hold(1'b1, h);
    hold(1'b0, l);
  endtask

  task automatic do_reset(input logic pin);
    Rst = 1'b0;
    hold(pin, 3);
    Rst = 1'b1;
    hold(pin, 10);
  endtask

  task automatic push_exp(input logic lost, input logic [DW-1:0] s);
    exp_q.push_back({lost, s});
  endtask

  task automatic drained(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{high: 8,    period: 2048, exp: 1};
    vecs[1] = '{high: 800,  period: 2048, exp: 100};
    vecs[2] = '{high: 2040, period: 2048, exp: 255};
    vecs[3] = '{high: 3000, period: 4096, exp: 255};
    vecs[4] = '{high: 1024, period: 2048, exp: 128};
    vecs[5] = '{high: 512,  period: 2048, exp: 64};

    // Reset state.
    Rst = 1'b0;
    hold(1'b0, 3);
    check("reset_sample", 32'(Sample), 32'd0);
    check("reset_valid", {31'd0, SampleValid}, 32'd0);
    check("reset_lost", {31'd0, Lost}, 32'd0);
    Rst = 1'b1;
    hold(1'b0, 10);

    // 50% duty, three periods: the first rise after idle publishes nothing.
    push_exp(1'b0, 8'd128);
    push_exp(1'b0, 8'd128);
    period(1024, 1024);
    period(1024, 1024);
    period(1024, 1024);
    drained("half_duty_drained");
    check("half_duty_lost", {31'd0, Lost}, 32'd0);

    // Duty sweep table, including an overlong period that saturates.
    for (int i = 0; i < 6; i++) begin
      do_reset(1'b0);
      push_exp(1'b0, 8'(vecs[i].exp));
      push_exp(1'b0, 8'(vecs[i].exp));
      period(vecs[i].high, vecs[i].period - vecs[i].high);
      period(vecs[i].high, vecs[i].period - vecs[i].high);
      hold(1'b1, 20);
      drained("sweep_drained");
    end

    // Stuck low after traffic, then recovery on a 25% waveform.
    do_reset(1'b0);
    push_exp(1'b0, 8'd128);
    period(1024, 1024);
    hold(1'b1, 1024);
    push_exp(1'b1, 8'd0);
    hold(1'b0, 9000);
    check("stuck_low_lost", {31'd0, Lost}, 32'd1);
    drained("stuck_low_drained");
    period(512, 1536);
    check("lost_held_idle_rise", {31'd0, Lost}, 32'd1);
    push_exp(1'b0, 8'd64);
    period(512, 1536);
    push_exp(1'b0, 8'd64);
    hold(1'b1, 20);
    drained("recover_drained");
    check("recover_lost", {31'd0, Lost}, 32'd0);

    // Stuck high from reset.
    do_reset(1'b1);
    push_exp(1'b1, 8'd255);
    hold(1'b1, 8400);
    check("stuck_high_lost", {31'd0, Lost}, 32'd1);
    drained("stuck_high_drained");

    // Reset 500 clocks into a high phase discards the partial period.
    do_reset(1'b0);
    push_exp(1'b0, 8'd128);
    period(1024, 1024);
    hold(1'b1, 500);
    Rst = 1'b0;
    hold(1'b1, 1);
    Rst = 1'b1;
    check("midreset_sample", 32'(Sample), 32'd0);
    check("midreset_valid", {31'd0, SampleValid}, 32'd0);
    check("midreset_lost", {31'd0, Lost}, 32'd0);
    hold(1'b1, 523);
    hold(1'b0, 1024);
    drained("midreset_quiet");
    push_exp(1'b0, 8'd128);
    period(1024, 1024);
    hold(1'b1, 20);
    drained("midreset_drained");

    // Two-clock spike inside the low phase of a 50% waveform.
    do_reset(1'b0);
`ifdef PWM_DEMOD_DEGLITCH_EN
    push_exp(1'b0, 8'd128);
    push_exp(1'b0, 8'd128);
`else
    push_exp(1'b0, 8'd128);
    push_exp(1'b0, 8'd0);
    push_exp(1'b0, 8'd128);
`endif
    hold(1'b1, 1024);
    hold(1'b0, 500);
    hold(1'b1, 2);
    hold(1'b0, 522);
    period(1024, 1024);
    hold(1'b1, 20);
    drained("spike_drained");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
